// File: rtl/data_mem_seq_pkg.sv
// Shared control encodings for the sequenced data memory: access size codes,
// FSM state encodings and the size/extension helpers used by the top.
package data_mem_seq_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      SIZE_BYTE: m = 4'b0001;
      SIZE_HALF: m = 4'b0011;
      default:   m = 4'b1111;
    endcase
    return m;
  endfunction

  // Sub-word loads extend from bit 7 (byte) or bit 15 (halfword).
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic is_unsigned);
    logic [31:0] r;
    case (sz)
      SIZE_BYTE: r = {{24{~is_unsigned & w[7]}}, w[7:0]};
      SIZE_HALF: r = {{16{~is_unsigned & w[15]}}, w[15:0]};
      default:   r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_seq_bank.sv
// Word-organised storage: one 32-bit word per address, four byte write
// enables, synchronous write and combinational read.
module data_mem_bank #(
  parameter int WORDS = 128
) (
  input  logic                     clk,
  input  logic [$clog2(WORDS)-1:0] i_addr,
  input  logic [3:0]               i_be,
  input  logic [31:0]              i_wdata,
  output logic [31:0]              o_rdata
);

  // Contents start at zero; reset deliberately does not touch the array.
  logic [31:0] r_mem [WORDS] = '{default: '0};

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_seq.sv
// Sequenced data memory: one request in flight, each storage beat takes
// READ_LATENCY cycles, word-crossing accesses are split into two beats.
module data_mem_seq
  import data_mem_seq_pkg::*;
#(
  parameter int DEPTH_BYTES      = 512,
  parameter int READ_LATENCY     = 1,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output state_t      dbg_state
);

  localparam int         WORDS  = DEPTH_BYTES / 4;
  localparam int         IDXW   = $clog2(WORDS);
  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  // Handshake: a request is taken on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE (and never during reset), every accepted
  // request gets exactly one resp_valid pulse, and resp has no back-pressure.

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [1:0]        r_off;
  logic [IDXW-1:0]   r_idx;
  logic [31:0]       r_wdata;
  logic              r_cross;
  logic [31:0]       r_lo_word;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;

  logic [2:0]        w_req_bytes;
  logic [32:0]       w_req_end;
  logic              w_req_cross;
  logic              w_req_err;
  logic              w_accept;
  logic              w_cnt_load;
  logic              w_cnt_zero;
  logic              w_beat_last;
  logic [IDXW-1:0]   w_bank_idx;
  logic [3:0]        w_be;
  logic [31:0]       w_bank_wdata;
  logic [31:0]       w_rd_word;
  logic [63:0]       w_lane_data;
  logic [7:0]        w_lane_mask;
  logic [31:0]       w_lo_word;
  logic [31:0]       w_aligned;
  logic [31:0]       w_load;

  // Range check on 33 bits so addresses near 2^32 cannot wrap into range.
  assign w_req_bytes = size_bytes(req_size);
  assign w_req_end   = {1'b0, req_addr} + {30'd0, w_req_bytes};
  assign w_req_cross = ({1'b0, req_addr[1:0]} + w_req_bytes) > 3'd4;
  assign w_req_err   = (w_req_end > 33'(DEPTH_BYTES)) ||
                       (w_req_cross && (ALLOW_MISALIGNED == 0));

  assign w_cnt_zero  = (r_cnt == 2'd0);
  assign w_beat_last = ((r_state == S_BEAT1) || (r_state == S_BEAT2)) && w_cnt_zero;

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_cnt_load = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept   = 1'b1;
          w_cnt_load = !w_req_err;
          w_next     = w_req_err ? S_RESP : S_BEAT1;
        end
      end
      S_BEAT1: begin
        if (w_cnt_zero) begin
          if (r_cross) begin
            w_next     = S_BEAT2;
            w_cnt_load = 1'b1;
          end else begin
            w_next = S_RESP;
          end
        end
      end
      S_BEAT2: if (w_cnt_zero) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Store bytes laid out across two words; BEAT1 owns the low half, BEAT2 the high.
  assign w_lane_data  = {32'd0, r_wdata} << {r_off, 3'b000};
  assign w_lane_mask  = {4'd0, size_mask(r_size)} << r_off;
  assign w_bank_idx   = (r_state == S_BEAT2) ? r_idx + 1'b1 : r_idx;
  assign w_bank_wdata = (r_state == S_BEAT2) ? w_lane_data[63:32] : w_lane_data[31:0];
  assign w_be         = (w_beat_last && r_we && !rst) ?
                        ((r_state == S_BEAT2) ? w_lane_mask[7:4] : w_lane_mask[3:0]) : 4'd0;

  data_mem_bank #(
    .WORDS (WORDS)
  ) u_bank (
    .clk     (clk),
    .i_addr  (w_bank_idx),
    .i_be    (w_be),
    .i_wdata (w_bank_wdata),
    .o_rdata (w_rd_word)
  );

  // Load data: the low word was latched at the end of BEAT1 for crossing reads.
  assign w_lo_word = (r_state == S_BEAT2) ? r_lo_word : w_rd_word;
  assign w_aligned = 32'({w_rd_word, w_lo_word} >> {r_off, 3'b000});
  assign w_load    = load_extend(w_aligned, r_size, r_unsigned);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 2'd0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_cnt_load)       r_cnt <= LAT_M1;
      else if (!w_cnt_zero) r_cnt <= r_cnt - 2'd1;
      r_resp_valid <= (w_next == S_RESP);
      r_resp_err   <= (w_next == S_RESP) && (r_state == S_IDLE);
      r_resp_rdata <= ((w_next == S_RESP) && (r_state != S_IDLE) && !r_we) ? w_load : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we       <= req_we;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_off      <= req_addr[1:0];
      r_idx      <= req_addr[IDXW+1:2];
      r_wdata    <= req_wdata;
      r_cross    <= w_req_cross;
    end
    if (w_beat_last && (r_state == S_BEAT1)) r_lo_word <= w_rd_word;
  end

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_data_mem_seq.sv
// Bench for data_mem_seq: three instances (default, READ_LATENCY=2,
// ALLOW_MISALIGNED=0) driven from a table of hand-computed vectors.
module tb_data_mem_seq;
  import data_mem_seq_pkg::*;

  localparam logic [1:0] B = SIZE_BYTE;
  localparam logic [1:0] H = SIZE_HALF;
  localparam logic [1:0] W = SIZE_WORD;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_we;
  logic [1:0]  req_size [3];
  logic [2:0]  req_unsigned;
  logic [31:0] req_addr [3];
  logic [31:0] req_wdata [3];
  logic [2:0]  resp_valid;
  logic [31:0] resp_rdata [3];
  logic [2:0]  resp_err;
  state_t      dbg_state [3];

  data_mem_seq #(.DEPTH_BYTES(512), .READ_LATENCY(1), .ALLOW_MISALIGNED(1)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .dbg_state(dbg_state[0]));

  data_mem_seq #(.DEPTH_BYTES(512), .READ_LATENCY(2), .ALLOW_MISALIGNED(1)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .dbg_state(dbg_state[1]));

  data_mem_seq #(.DEPTH_BYTES(512), .READ_LATENCY(1), .ALLOW_MISALIGNED(0)) u_dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]),
    .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .dbg_state(dbg_state[2]));

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    int          dut;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int d, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                     input logic err, input int lat);
    vec_t v;
    v.dut = d; v.we = we; v.sz = sz; v.uns = uns; v.addr = addr;
    v.wd = wd; v.rd = rd; v.err = err; v.lat = lat;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  // Entered just after a falling edge; returns just after a falling edge.
  task automatic do_req(input int d, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input string tag,
                        output logic [31:0] rd, output logic er, output int lat);
    logic found;
    check({tag, " ready"}, 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz; req_unsigned[d] = uns;
    req_addr[d] = addr; req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = 32'hDEAD_0000;
    found = 1'b0; lat = -1; rd = '0; er = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (resp_valid[d]) begin
        found = 1'b1; lat = i; rd = resp_rdata[d]; er = resp_err[d];
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: resp_valid not seen within 20 cycles, required 1", tag);
    end
    @(negedge clk);
    check({tag, " pulse"}, 32'(resp_valid[d]), 32'd0);
  endtask

  // ---------------- test ----------------
  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = W; req_unsigned[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d reset ready", d), 32'(req_ready[d]), 32'd0);
      check($sformatf("dut%0d reset resp_valid", d), 32'(resp_valid[d]), 32'd0);
      check($sformatf("dut%0d reset resp_err", d), 32'(resp_err[d]), 32'd0);
      check($sformatf("dut%0d reset rdata", d), resp_rdata[d], 32'd0);
      check($sformatf("dut%0d reset state", d), 32'(dbg_state[d]), 32'(S_IDLE));
    end
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("dut%0d ready after reset", d), 32'(req_ready[d]), 32'd1);

    // dut, we, size, uns, addr, wdata, exp rdata, exp err, exp latency
    add(0, 1, W, 0, 32'h010, 32'h8899AABB, 32'h00000000, 0, 2);
    add(0, 0, W, 0, 32'h010, 32'h0,        32'h8899AABB, 0, 2);
    add(0, 0, H, 0, 32'h010, 32'h0,        32'hFFFFAABB, 0, 2);
    add(0, 0, H, 1, 32'h012, 32'h0,        32'h00008899, 0, 2);
    add(0, 1, W, 0, 32'h020, 32'hA1B2C3D4, 32'h00000000, 0, 2);
    add(0, 1, B, 0, 32'h021, 32'hFFFFFF80, 32'h00000000, 0, 2);
    add(0, 0, B, 0, 32'h021, 32'h0,        32'hFFFFFF80, 0, 2);
    add(0, 0, B, 1, 32'h021, 32'h0,        32'h00000080, 0, 2);
    add(0, 0, W, 0, 32'h020, 32'h0,        32'hA1B280D4, 0, 2);
    add(0, 0, H, 0, 32'h022, 32'h0,        32'hFFFFA1B2, 0, 2);
    add(0, 0, H, 1, 32'h022, 32'h0,        32'h0000A1B2, 0, 2);
    add(0, 0, B, 0, 32'h023, 32'h0,        32'hFFFFFFA1, 0, 2);
    add(0, 0, B, 0, 32'h020, 32'h0,        32'hFFFFFFD4, 0, 2);
    add(0, 1, H, 0, 32'h032, 32'h1234ABCD, 32'h00000000, 0, 2);
    add(0, 0, W, 0, 32'h030, 32'h0,        32'hABCD0000, 0, 2);
    add(0, 1, H, 0, 32'h043, 32'h0000BEEF, 32'h00000000, 0, 3);
    add(0, 0, W, 0, 32'h040, 32'h0,        32'hEF000000, 0, 2);
    add(0, 0, W, 0, 32'h044, 32'h0,        32'h000000BE, 0, 2);
    add(0, 0, H, 1, 32'h043, 32'h0,        32'h0000BEEF, 0, 3);
    add(0, 0, H, 0, 32'h043, 32'h0,        32'hFFFFBEEF, 0, 3);
    add(0, 0, W, 0, 32'h013, 32'h0,        32'h00000088, 0, 3);
    add(0, 1, W, 0, 32'h1FC, 32'h0BADF00D, 32'h00000000, 0, 2);
    add(0, 0, W, 0, 32'h1FC, 32'h0,        32'h0BADF00D, 0, 2);
    add(0, 1, W, 0, 32'h1FE, 32'hFFFFFFFF, 32'h00000000, 1, 1);
    add(0, 0, W, 0, 32'h1FC, 32'h0,        32'h0BADF00D, 0, 2);
    add(0, 0, B, 0, 32'h1FF, 32'h0,        32'h0000000B, 0, 2);
    add(0, 0, B, 1, 32'h200, 32'h0,        32'h00000000, 1, 1);
    add(0, 0, W, 0, 32'h1FD, 32'h0,        32'h00000000, 1, 1);
    add(0, 0, H, 0, 32'hFFFFFFFF, 32'h0,   32'h00000000, 1, 1);
    add(1, 1, W, 0, 32'h00E, 32'h11223344, 32'h00000000, 0, 5);
    add(1, 0, W, 0, 32'h00C, 32'h0,        32'h33440000, 0, 3);
    add(1, 0, W, 0, 32'h010, 32'h0,        32'h00001122, 0, 3);
    add(1, 0, W, 0, 32'h00E, 32'h0,        32'h11223344, 0, 5);
    add(1, 0, H, 0, 32'h00F, 32'h0,        32'h00002233, 0, 5);
    add(1, 0, B, 0, 32'h00E, 32'h0,        32'h00000044, 0, 3);
    add(2, 0, H, 0, 32'h003, 32'h0,        32'h00000000, 1, 1);
    add(2, 1, W, 0, 32'h020, 32'h01020304, 32'h00000000, 0, 2);
    add(2, 1, H, 0, 32'h023, 32'h0000FFFF, 32'h00000000, 1, 1);
    add(2, 0, W, 0, 32'h020, 32'h0,        32'h01020304, 0, 2);
    add(2, 0, H, 1, 32'h022, 32'h0,        32'h00000102, 0, 2);
    add(2, 0, W, 0, 32'h021, 32'h0,        32'h00000000, 1, 1);
    add(2, 0, W, 0, 32'h1FE, 32'h0,        32'h00000000, 1, 1);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      do_req(vecs[i].dut, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
             tag, rd, er, lat);
      check({tag, " rdata"}, rd, vecs[i].rd);
      check({tag, " err"}, 32'(er), 32'(vecs[i].err));
      check({tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Reset during BEAT2 of a crossing store (READ_LATENCY=2 instance).
    do_req(1, 1, W, 0, 32'h02C, 32'hCAFEBABE, "pre2c", rd, er, lat);
    do_req(1, 1, W, 0, 32'h030, 32'hDEADBEEF, "pre30", rd, er, lat);
    check("rstmid ready", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = W; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h02E; req_wdata[1] = 32'h11223344;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid in beat2", 32'(dbg_state[1]), 32'(S_BEAT2));
    rst = 1'b1;
    @(negedge clk);
    check("rstmid state", 32'(dbg_state[1]), 32'(S_IDLE));
    check("rstmid ready low", 32'(req_ready[1]), 32'd0);
    check("rstmid no resp", 32'(resp_valid[1]), 32'd0);
    check("rstmid rdata", resp_rdata[1], 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid ready high", 32'(req_ready[1]), 32'd1);
    check("rstmid still no resp", 32'(resp_valid[1]), 32'd0);
    do_req(1, 0, W, 0, 32'h02C, 32'h0, "rstmid ld2c", rd, er, lat);
    check("rstmid beat1 word", rd, 32'h3344BABE);
    do_req(1, 0, W, 0, 32'h030, 32'h0, "rstmid ld30", rd, er, lat);
    check("rstmid beat2 word", rd, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1);
  end

endmodule
